match_event_logger: RTL and testbench
=====================================

MATCH_EVENT_LOGGER -- requirements
Module: match_event_logger

Interface
REQ-001 Parameter: DEPTH, 4, number of FIFO entries (power of two, 2..16).
REQ-002 Parameter: TS_WIDTH, 8, timestamp width in bits.
REQ-003 Port: clk  input  1  single clock; all logic on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: count  input  4  counter value from the upstream counter/comparator stage.
REQ-006 Port: match  input  1  comparator output from the same stage.
REQ-007 Port: clear  input  1  synchronous clear of the statistics outputs.
REQ-008 Port: out_valid  output  1  FIFO head entry available.
REQ-009 Port: out_ready  input  1  consumer accepts the head entry.
REQ-010 Port: out_data  output  TS_WIDTH+4  head entry, {timestamp, count}, timestamp in the MSBs.
REQ-011 Port: fifo_level  output  $clog2(DEPTH+1)  number of stored entries.
REQ-012 Port: event_total  output  8  saturating count of detected match events.
REQ-013 Port: overflow  output  1  sticky flag: one or more events were dropped.

Function
REQ-014 Free-running timestamp counter: +1 every cycle, wraps from 2^TS_WIDTH-1 to 0.
REQ-015 Event is detected in cycle t when match=1 and registered match_q=0 (rising edge only); a held match produces exactly one event.
REQ-016 On an event, push {timestamp(t), count(t)}, both sampled in cycle t.
REQ-017 No bypass: an entry pushed in cycle t is first visible on out_valid/out_data in cycle t+1.
REQ-018 Pop occurs when out_valid=1 and out_ready=1; the next entry (if any) appears in the following cycle.
REQ-019 While out_valid=1 and out_ready=0, out_data holds stable.
REQ-020 out_valid=0 when fifo_level=0; out_data is don't-care then.
REQ-021 Full (fifo_level=DEPTH), event, no pop: event dropped, overflow set to 1; contents unchanged.
REQ-022 Full, event, pop in the same cycle: push accepted, level stays DEPTH, overflow unchanged.
REQ-023 Empty, event, out_ready=1: push accepted, no pop, level becomes 1.
REQ-024 event_total increments on every detected event, including dropped events, and saturates at 255.
REQ-025 clear=1 sets event_total to 0 and overflow to 0; a simultaneous event leaves event_total=1, and a simultaneous drop leaves overflow=1.
REQ-026 clear does not affect FIFO contents, fifo_level, or the timestamp.
REQ-027 fifo_level is registered and reflects all pushes and pops of the previous cycle.

Reset
REQ-028 reset=1 sets: timestamp=0, FIFO empty, fifo_level=0, out_valid=0, event_total=0, overflow=0.
REQ-029 reset=1 sets match_q=1, so a match already high on reset release produces no event.
REQ-030 reset has priority over clear, events and pops, and discards in-flight entries mid-operation.
REQ-031 No output depends combinationally on reset.

Structure
REQ-032 Shared package soc_pkg holds: COUNT_WIDTH=4, default TS_WIDTH, default DEPTH, and the log-entry typedef {timestamp, count}.
REQ-033 Storage is one sub-module, sync_fifo: parameterised width/depth, push/pop/full/empty/level, synchronous active-high reset.
REQ-034 Edge detection, the timestamp counter and statistics live in match_event_logger; it has no other sub-modules.

Verification
REQ-035 Reset release with match=1 held 3 cycles -> no push, event_total=0, out_valid=0.
REQ-036 After reset, match pulse at timestamp=5 with count=9, out_ready=1 -> next cycle out_valid=1, out_data={8'd5,4'd9}, popped that cycle, level returns to 0.
REQ-037 out_ready=0, 5 single-cycle match pulses with DEPTH=4 -> level=4, overflow=1, event_total=5; draining returns the first 4 entries in order.
REQ-038 Full FIFO with event and pop in the same cycle -> level stays 4, overflow stays 0, newest entry is last out.
REQ-039 300 match pulses -> event_total=255; then clear together with an event -> event_total=1, overflow=0.
REQ-040 Assert reset with 3 entries queued -> next cycle level=0, out_valid=0; timestamp restarts at 0 and wraps 255->0 with no glitch in later entries.

Source files
------------

// File: rtl/soc_pkg.sv
// Shared definitions for the match event logger slice: widths, defaults and log-entry layout.
package soc_pkg;

  localparam int unsigned COUNT_WIDTH      = 4;
  localparam int unsigned DEFAULT_TS_WIDTH = 8;
  localparam int unsigned DEFAULT_DEPTH    = 4;

  // One logged event; timestamp occupies the MSBs.
  typedef struct packed {
    logic [DEFAULT_TS_WIDTH-1:0] timestamp;
    logic [COUNT_WIDTH-1:0]      count;
  } log_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered level; head entry is read directly from storage (no bypass).
module sync_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH+1);
  localparam logic [LW-1:0] FullLevel = LW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full   = (r_level == FullLevel);
  assign o_empty  = (r_level == '0);
  assign o_level  = r_level;
  assign o_data   = r_mem[r_rd_ptr];

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign w_push_ok = i_push & (~o_full | i_pop);
  assign w_pop_ok  = i_pop & ~o_empty;

  // Storage write; pointers alone define validity, so the array needs no reset.
  always_ff @(posedge clk) begin
    if (!reset && w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and level bookkeeping; reset discards everything queued.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/match_event_logger.sv
// Logs rising edges of the comparator match as {timestamp, count} entries into a FIFO and keeps
// event statistics (saturating total, sticky overflow).
module match_event_logger
  import soc_pkg::*;
#(
  parameter int unsigned DEPTH    = DEFAULT_DEPTH,
  parameter int unsigned TS_WIDTH = DEFAULT_TS_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [COUNT_WIDTH-1:0]          count,
  input  logic                            match,
  input  logic                            clear,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [TS_WIDTH+COUNT_WIDTH-1:0] out_data,
  output logic [$clog2(DEPTH+1)-1:0]      fifo_level,
  output logic [7:0]                      event_total,
  output logic                            overflow
);

  localparam int unsigned EntryWidth = TS_WIDTH + COUNT_WIDTH;

  logic [TS_WIDTH-1:0]   r_ts;
  logic                  r_match_q;
  logic [7:0]            r_event_total;
  logic                  r_overflow;

  logic                  w_event;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_drop;
  logic [EntryWidth-1:0] w_push_data;

  assign w_event     = match & ~r_match_q;
  assign w_pop       = out_valid & out_ready;
  assign w_drop      = w_event & w_full & ~w_pop;
  assign w_push_data = {r_ts, count};

  assign out_valid   = ~w_empty;
  assign event_total = r_event_total;
  assign overflow    = r_overflow;

  // Free-running timestamp, wraps naturally at its width.
  always_ff @(posedge clk) begin
    if (reset) r_ts <= '0;
    else       r_ts <= r_ts + 1'b1;
  end

  // Match history; forced high in reset so a match held across reset release is not an event.
  always_ff @(posedge clk) begin
    if (reset) r_match_q <= 1'b1;
    else       r_match_q <= match;
  end

  // Saturating event counter; an event coinciding with clear is still counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_event_total <= '0;
    end else if (clear) begin
      r_event_total <= {7'd0, w_event};
    end else if (w_event && (r_event_total != 8'hff)) begin
      r_event_total <= r_event_total + 8'd1;
    end
  end

  // Sticky drop flag; a drop wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset)       r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
    else if (clear)  r_overflow <= 1'b0;
  end

  sync_fifo #(
    .WIDTH (EntryWidth),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_event),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (out_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

endmodule

// File: tb/tb_match_event_logger.sv
// Directed bench for match_event_logger (DEPTH=4, TS_WIDTH=8).
module tb_match_event_logger;
  import soc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  count;
  logic        match;
  logic        clear;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  logic [2:0]  fifo_level;
  logic [7:0]  event_total;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  // Timestamp the DUT holds during the current cycle.
  logic [7:0] ts_now;
  logic [7:0] exp_ts [5];

  always #5 clk = ~clk;

  match_event_logger #(
    .DEPTH    (4),
    .TS_WIDTH (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .count       (count),
    .match       (match),
    .clear       (clear),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .fifo_level  (fifo_level),
    .event_total (event_total),
    .overflow    (overflow)
  );

  function automatic log_entry_t mk(input logic [7:0] ts, input logic [3:0] cnt);
    log_entry_t e;
    e.timestamp = ts;
    e.count     = cnt;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) ts_now = 8'd0;
    else       ts_now = ts_now + 8'd1;
    #1;
  endtask

  task automatic pulse(input logic [3:0] cnt, input int idx);
    count = cnt;
    if (idx >= 0) exp_ts[idx] = ts_now;
    match = 1'b1;
    tick();
    match = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; match = 1'b0; count = '0; clear = 1'b0; out_ready = 1'b0;
    tick(); tick();
    check("rst_valid", out_valid, 0);
    check("rst_level", fifo_level, 0);
    check("rst_total", event_total, 0);
    check("rst_ovf", overflow, 0);

    // Match held across reset release
    match = 1'b1;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check("held_level", fifo_level, 0);
    check("held_valid", out_valid, 0);
    check("held_total", event_total, 0);

    // Single pulse at timestamp 5, consumer ready
    match = 1'b0;
    do_reset();
    repeat (5) tick();
    check("ts5_reached", ts_now, 5);
    count = 4'd9; match = 1'b1; out_ready = 1'b1;
    tick();
    match = 1'b0;
    check("one_valid", out_valid, 1);
    check("one_data", out_data, 32'(mk(8'd5, 4'd9)));
    check("one_level", fifo_level, 1);
    tick();
    check("one_popped_level", fifo_level, 0);
    check("one_popped_valid", out_valid, 0);
    check("one_total", event_total, 1);

    // Overflow: five pulses into a four-entry FIFO
    out_ready = 1'b0;
    do_reset();
    tick();
    for (int i = 0; i < 5; i++) begin
      pulse(4'(i + 1), i);
      if (i == 3) begin
        check("fill4_level", fifo_level, 4);
        check("fill4_ovf", overflow, 0);
      end
    end
    check("ovf_level", fifo_level, 4);
    check("ovf_flag", overflow, 1);
    check("ovf_total", event_total, 5);
    check("ovf_head_hold", out_data, 32'(mk(exp_ts[0], 4'd1)));

    // Clear alone resets statistics but not the FIFO
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_ovf", overflow, 0);
    check("clr_total", event_total, 0);
    check("clr_level", fifo_level, 4);

    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", out_valid, 1);
      check("drain_data", out_data, 32'(mk(exp_ts[i], 4'(i + 1))));
      tick();
    end
    check("drain_level", fifo_level, 0);
    check("drain_empty", out_valid, 0);

    // Full FIFO: event and pop in the same cycle
    out_ready = 1'b0;
    do_reset();
    tick();
    for (int i = 0; i < 4; i++) pulse(4'(i + 1), i);
    count = 4'd5; exp_ts[4] = ts_now; match = 1'b1; out_ready = 1'b1;
    tick();
    match = 1'b0; out_ready = 1'b0;
    check("fullpp_level", fifo_level, 4);
    check("fullpp_ovf", overflow, 0);
    check("fullpp_total", event_total, 5);
    out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      check("fullpp_data", out_data, 32'(mk(exp_ts[i], 4'(i + 1))));
      tick();
    end
    check("fullpp_empty", out_valid, 0);

    // Saturation, then clear together with an event
    do_reset();
    tick();
    for (int i = 0; i < 300; i++) pulse(4'd7, -1);
    check("sat_total", event_total, 255);
    check("sat_ovf", overflow, 0);
    check("sat_level", fifo_level, 0);
    match = 1'b1; clear = 1'b1;
    tick();
    match = 1'b0; clear = 1'b0;
    check("clrev_total", event_total, 1);
    check("clrev_ovf", overflow, 0);
    check("clrev_level", fifo_level, 1);
    out_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) pulse(4'd2, -1);
    check("drop_ovf", overflow, 1);
    check("drop_total", event_total, 5);
    match = 1'b1; clear = 1'b1;
    tick();
    match = 1'b0; clear = 1'b0;
    check("clrdrop_ovf", overflow, 1);
    check("clrdrop_total", event_total, 1);
    check("clrdrop_level", fifo_level, 4);

    // Reset mid-operation, then timestamp wrap
    do_reset();
    tick();
    for (int i = 0; i < 3; i++) pulse(4'd4, -1);
    check("pre_rst_level", fifo_level, 3);
    reset = 1'b1;
    tick();
    check("midrst_level", fifo_level, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_total", event_total, 0);
    reset = 1'b0;
    tick();
    count = 4'd3; match = 1'b1;
    tick();
    match = 1'b0;
    check("restart_data", out_data, 32'(mk(8'd1, 4'd3)));
    repeat (252) tick();
    check("ts254_reached", ts_now, 254);
    count = 4'd10; match = 1'b1;
    tick();
    match = 1'b0;
    tick(); tick();
    count = 4'd11; match = 1'b1;
    tick();
    match = 1'b0;
    check("wrap_level", fifo_level, 3);
    out_ready = 1'b1;
    check("wrap_d0", out_data, 32'(mk(8'd1, 4'd3)));
    tick();
    check("wrap_d1", out_data, 32'(mk(8'd254, 4'd10)));
    tick();
    check("wrap_d2", out_data, 32'(mk(8'd1, 4'd11)));
    tick();
    check("wrap_empty", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
